// File: rtl/demux_stream_1to2_pkg.sv
// Shared types and constants for the 1-to-2 stream demultiplexer.
// Occupancy encoding is shared between the tagged FIFO and the steering top.
package demux_stream_1to2_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/demux_stream_1to2_if.sv
// Producer-side and two consumer-side valid/ready channels of the demux.
// slave is the demux view, master is the producer/consumer view.
interface demux_stream_1to2_if
  import demux_stream_1to2_pkg::*;
#(
  parameter int unsigned N = DATA_W
);

  logic [N-1:0] InData;
  logic         InSel;
  logic         InValid;
  logic         InReady;

  logic [N-1:0] Out0Data;
  logic         Out0Valid;
  logic         Out0Ready;

  logic [N-1:0] Out1Data;
  logic         Out1Valid;
  logic         Out1Ready;

  modport slave (
    input  InData, InSel, InValid, Out0Ready, Out1Ready,
    output InReady, Out0Data, Out0Valid, Out1Data, Out1Valid
  );

  modport master (
    output InData, InSel, InValid, Out0Ready, Out1Ready,
    input  InReady, Out0Data, Out0Valid, Out1Data, Out1Valid
  );

endinterface

// File: rtl/demux_stream_1to2_fifo2_tagged.sv
// Two-entry {sel,data} FIFO with 1-bit wrap pointers; exposes head and occupancy.
// Storage is cleared on reset so the head reads zero until the first push.
module fifo2_tagged
  import demux_stream_1to2_pkg::*;
#(
  parameter int unsigned N = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         in_sel,
  input  logic [N-1:0] in_data,
  output state_e       state,
  output logic         head_sel,
  output logic [N-1:0] head_data
);

  state_e       state_q, state_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   sel_q, sel_d;
  logic [N-1:0] data_q [2];
  logic [N-1:0] data_d [2];
  logic         do_push;
  logic         do_pop;

  always_comb begin
    do_push  = push & (state_q != FULL);
    do_pop   = pop & (state_q != EMPTY);
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    sel_d    = sel_q;
    data_d   = data_q;

    if (do_push) begin
      sel_d[wr_ptr_q]  = in_sel;
      data_d[wr_ptr_q] = in_data;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    unique case (state_q)
      EMPTY:   if (do_push) state_d = ONE;
      ONE: begin
        if (do_push && !do_pop) state_d = FULL;
        else if (do_pop && !do_push) state_d = EMPTY;
      end
      FULL:    if (do_pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      sel_q    <= '0;
      data_q   <= '{default: '0};
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
    end
  end

  assign state     = state_q;
  assign head_sel  = sel_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];

endmodule

// File: rtl/demux_stream_1to2.sv
// Registered 1-to-2 stream demux: tagged words leave in arrival order on the
// port named by their tag; a blocked head stalls everything behind it.
module demux_stream_1to2
  import demux_stream_1to2_pkg::*;
#(
  parameter int unsigned N = DATA_W
) (
  input  logic                       Clk,
  input  logic                       Rst,
  demux_stream_1to2_if.slave         bus
);

  state_e       state;
  logic         head_sel;
  logic [N-1:0] head_data;
  logic         in_ready;
  logic         out0_valid;
  logic         out1_valid;
  logic         push;
  logic         pop;

  always_comb begin
    in_ready   = (state != FULL) & ~Rst;
    out0_valid = (state != EMPTY) & ~head_sel;
    out1_valid = (state != EMPTY) & head_sel;
    push       = bus.InValid & in_ready;
    // Ready on the port the head is not bound for is ignored.
    pop        = (out0_valid & bus.Out0Ready) | (out1_valid & bus.Out1Ready);
  end

  fifo2_tagged #(
    .N (N)
  ) u_fifo (
    .clk       (Clk),
    .rst       (Rst),
    .push      (push),
    .pop       (pop),
    .in_sel    (bus.InSel),
    .in_data   (bus.InData),
    .state     (state),
    .head_sel  (head_sel),
    .head_data (head_data)
  );

  assign bus.InReady   = in_ready;
  assign bus.Out0Valid = out0_valid;
  assign bus.Out1Valid = out1_valid;
  assign bus.Out0Data  = head_data;
  assign bus.Out1Data  = head_data;

endmodule

// File: tb/tb_demux_stream_1to2.sv
// Scoreboarded bench for demux_stream_1to2: accepted words are queued in order
// and matched against whichever port pops them.
module tb_demux_stream_1to2;

  typedef struct {
    logic        sel;
    logic [31:0] data;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  word_t sb [$];

  logic        hold0, hold1;
  logic [31:0] hold0_data, hold1_data;
  logic        accepted;

  demux_stream_1to2_if #(.N(32)) bus ();

  demux_stream_1to2 #(.N(32)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      hold0 = 1'b0;
      hold1 = 1'b0;
    end else begin
      check_eq("valid_exclusive", {63'd0, bus.Out0Valid & bus.Out1Valid}, 64'd0);
      if (hold0) begin
        check_eq("hold0_valid", {63'd0, bus.Out0Valid}, 64'd1);
        check_eq("hold0_data", {32'd0, bus.Out0Data}, {32'd0, hold0_data});
      end
      if (hold1) begin
        check_eq("hold1_valid", {63'd0, bus.Out1Valid}, 64'd1);
        check_eq("hold1_data", {32'd0, bus.Out1Data}, {32'd0, hold1_data});
      end
      if ((bus.Out0Valid && bus.Out0Ready) || (bus.Out1Valid && bus.Out1Ready)) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_output", 64'd1, 64'd0);
        end else begin
          word_t w;
          w = sb.pop_front();
          check_eq("out_port", {63'd0, bus.Out1Valid}, {63'd0, w.sel});
          check_eq("out_data", {32'd0, (bus.Out1Valid ? bus.Out1Data : bus.Out0Data)},
                   {32'd0, w.data});
        end
      end
      if (bus.InValid && bus.InReady) sb.push_back('{sel: bus.InSel, data: bus.InData});
      hold0      = bus.Out0Valid & ~bus.Out0Ready;
      hold1      = bus.Out1Valid & ~bus.Out1Ready;
      hold0_data = bus.Out0Data;
      hold1_data = bus.Out1Data;
    end
  end

  initial begin
    bus.InData    = '0;
    bus.InSel     = 1'b0;
    bus.InValid   = 1'b0;
    bus.Out0Ready = 1'b0;
    bus.Out1Ready = 1'b0;

    // Reset values
    tick;
    tick;
    check_eq("rst_in_ready", {63'd0, bus.InReady}, 64'd0);
    check_eq("rst_out0_valid", {63'd0, bus.Out0Valid}, 64'd0);
    check_eq("rst_out1_valid", {63'd0, bus.Out1Valid}, 64'd0);
    check_eq("rst_out0_data", {32'd0, bus.Out0Data}, 64'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", {63'd0, bus.InReady}, 64'd1);

    // Single word to port 0
    bus.InData = 32'h1111_1111; bus.InSel = 1'b0; bus.InValid = 1'b1; bus.Out0Ready = 1'b1;
    tick;
    bus.InValid = 1'b0;
    check_eq("single_out0_valid", {63'd0, bus.Out0Valid}, 64'd1);
    check_eq("single_out0_data", {32'd0, bus.Out0Data}, 64'h1111_1111);
    check_eq("single_out1_valid", {63'd0, bus.Out1Valid}, 64'd0);
    tick;
    check_eq("single_popped", {63'd0, bus.Out0Valid}, 64'd0);
    check_eq("single_out1_idle", {63'd0, bus.Out1Valid}, 64'd0);

    // Back-to-back stream on port 1
    bus.Out0Ready = 1'b0; bus.Out1Ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.InData = 32'hA0 + i; bus.InSel = 1'b1; bus.InValid = 1'b1;
      #1;
      check_eq("stream_in_ready", {63'd0, bus.InReady}, 64'd1);
      tick;
      check_eq("stream_out1_valid", {63'd0, bus.Out1Valid}, 64'd1);
      check_eq("stream_out1_data", {32'd0, bus.Out1Data}, 64'hA0 + 64'(i));
    end
    bus.InValid = 1'b0;
    tick;
    check_eq("stream_drained", {63'd0, bus.Out1Valid}, 64'd0);

    // Head-of-line blocking
    bus.Out1Ready = 1'b0; bus.Out0Ready = 1'b1;
    bus.InData = 32'hB0; bus.InSel = 1'b1; bus.InValid = 1'b1;
    tick;
    bus.InData = 32'hB1; bus.InSel = 1'b0;
    tick;
    bus.InValid = 1'b0;
    check_eq("hol_in_ready_full", {63'd0, bus.InReady}, 64'd0);
    check_eq("hol_out1_valid", {63'd0, bus.Out1Valid}, 64'd1);
    check_eq("hol_out1_data", {32'd0, bus.Out1Data}, 64'hB0);
    check_eq("hol_out0_blocked", {63'd0, bus.Out0Valid}, 64'd0);
    tick;
    check_eq("hol_still_blocked", {63'd0, bus.Out0Valid}, 64'd0);
    bus.Out1Ready = 1'b1;
    tick;
    check_eq("hol_out0_valid", {63'd0, bus.Out0Valid}, 64'd1);
    check_eq("hol_out0_data", {32'd0, bus.Out0Data}, 64'hB1);
    tick;
    check_eq("hol_empty", {63'd0, bus.Out0Valid | bus.Out1Valid}, 64'd0);

    // Full stall: third word waits for the first pop
    bus.Out0Ready = 1'b0; bus.Out1Ready = 1'b0;
    bus.InSel = 1'b0; bus.InValid = 1'b1;
    bus.InData = 32'hC0; tick;
    bus.InData = 32'hC1; tick;
    bus.InData = 32'hC2;
    check_eq("stall_in_ready", {63'd0, bus.InReady}, 64'd0);
    tick;
    check_eq("stall_in_ready_2", {63'd0, bus.InReady}, 64'd0);
    check_eq("stall_head", {32'd0, bus.Out0Data}, 64'hC0);
    bus.Out0Ready = 1'b1;
    tick;
    check_eq("stall_released", {63'd0, bus.InReady}, 64'd1);
    check_eq("stall_second", {32'd0, bus.Out0Data}, 64'hC1);
    tick;
    bus.InValid = 1'b0;
    check_eq("stall_third", {32'd0, bus.Out0Data}, 64'hC2);
    tick;
    check_eq("stall_empty", {63'd0, bus.Out0Valid}, 64'd0);

    // Reset while FULL
    bus.Out1Ready = 1'b0; bus.InSel = 1'b1; bus.InValid = 1'b1;
    bus.InData = 32'hD0; tick;
    bus.InData = 32'hD1; tick;
    bus.InValid = 1'b0;
    check_eq("pre_rst_full", {63'd0, bus.InReady}, 64'd0);
    bus.Out1Ready = 1'b1;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_in_ready", {63'd0, bus.InReady}, 64'd0);
    tick;
    rst = 1'b0;
    #1;
    check_eq("mid_rst_out0_valid", {63'd0, bus.Out0Valid}, 64'd0);
    check_eq("mid_rst_out1_valid", {63'd0, bus.Out1Valid}, 64'd0);
    check_eq("mid_rst_data", {32'd0, bus.Out1Data}, 64'd0);
    check_eq("mid_rst_in_ready_after", {63'd0, bus.InReady}, 64'd1);
    tick;
    tick;

    // Random traffic; producer holds its word until accepted
    accepted = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (!bus.InValid || accepted) begin
        bus.InValid = 1'($urandom_range(0, 1));
        bus.InSel   = 1'($urandom_range(0, 1));
        bus.InData  = $urandom;
      end
      bus.Out0Ready = 1'($urandom_range(0, 1));
      bus.Out1Ready = 1'($urandom_range(0, 1));
      #1;
      accepted = bus.InValid & bus.InReady;
      tick;
    end
    bus.InValid = 1'b0; bus.Out0Ready = 1'b1; bus.Out1Ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick;
    tick;
    check_eq("drain_scoreboard", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
